// File: rtl/subleq_bus_ctrl.sv
// rtl/subleq_bus_ctrl.sv - run controller and memory-bus owner for the SUBLEQ core
//
// Arbitrates the single memory bus between a host port (program load and
// readback) and the SUBLEQ core. The core is held in reset while the host
// owns the bus. Start releases the core from pc=0. The controller follows the
// core's fixed 6-phase instruction ring and stops the core only at an
// instruction boundary. A stop happens on a fetch of HALT_ADDR, or on a host
// stop request.
//
// Optional feature macro: SUBLEQ_RETIRE_CNT_EN
//   When defined, this adds the retire_cnt output and the MAX_INSTR retire limit.
//
// Ports
//   clk          clock
//   rst          async reset, active-low
//   start        pulse, starts the core from pc=0 (honoured in IDLE only)
//   host_req     level, host bus request (also a stop request while running)
//   host_gnt     host owns the bus
//   host_valid   host access this cycle
//   host_we      host access is a write
//   host_addr    host byte address
//   host_wdata   host write data, raw bus byte order
//   host_rdata   registered host read data
//   host_rvalid  host_rdata valid, one cycle after the read
//   core_rst     core reset, active-low
//   cpu_en       core bus-drive enable
//   busy         core running
//   halted       sticky, core stopped on HALT_ADDR fetch
//   mem_we       shared bus write enable
//   mem_addr     shared bus address
//   mem_data     shared bus data
//   retire_cnt   retired instruction count (SUBLEQ_RETIRE_CNT_EN only)

module subleq_bus_ctrl #(
  parameter logic [31:0] HALT_ADDR = 32'hFFFF_FFFC,
  parameter logic [31:0] MAX_INSTR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        host_req,
  output logic        host_gnt,
  input  logic        host_valid,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  output logic        core_rst,
  output logic        cpu_en,
  output logic        busy,
  output logic        halted,
  inout  wire         mem_we,
  inout  wire  [31:0] mem_addr,
  inout  wire  [31:0] mem_data
`ifdef SUBLEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOST = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] phase;
  logic       stop_pend;
  logic       run_q;
  logic       host_acc;
  logic       host_wr;
  logic       host_rd;
  logic       start_run;
  logic       halt_hit;
  logic       limit_hit;

  assign run_q    = (state == ST_RUN);
  assign host_acc = (state == ST_HOST) && host_valid;
  assign host_wr  = host_acc && host_we;
  assign host_rd  = host_acc && !host_we;

  // The core owns the address/control lines for the whole RUN state. Outside
  // RUN the controller parks the bus at address 0 with no write.
  assign mem_we   = run_q ? 1'bz : host_wr;
  assign mem_addr = run_q ? 32'bz : (host_acc ? host_addr : 32'd0);
  assign mem_data = host_wr ? host_wdata : 32'bz;

  // Gating with rst lets the core drop into reset together with the
  // controller, without waiting for a clock edge.
  assign core_rst = rst & run_q;
  assign cpu_en   = run_q;
  assign busy     = run_q;
  assign host_gnt = (state == ST_HOST);

`ifdef SUBLEQ_RETIRE_CNT_EN
  logic [31:0] retire_inc;
  assign retire_inc = (retire_cnt == 32'hFFFF_FFFF) ? retire_cnt : retire_cnt + 32'd1;
  // The comparison is only acted on in phase 5, where retire_inc is the count
  // that includes the instruction retiring now.
  assign limit_hit  = (MAX_INSTR != 32'd0) && (retire_inc == MAX_INSTR);
`else
  assign limit_hit = 1'b0;
  if (MAX_INSTR != 32'd0) begin : g_max_instr_unused
  end
`endif

  always_comb begin
    state_nx  = state;
    start_run = 1'b0;
    halt_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (host_req) begin
          state_nx = ST_HOST;
        end else if (start) begin
          state_nx  = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_HOST: begin
        if (!host_req) state_nx = ST_IDLE;
      end
      ST_RUN: begin
        // A halt fetch takes priority over a pending stop. The fetched
        // instruction is never executed.
        if (phase == 3'd0 && mem_addr == HALT_ADDR) begin
          halt_hit = 1'b1;
          state_nx = ST_IDLE;
        end else if (phase == 3'd5 && (stop_pend || host_req || limit_hit)) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      phase       <= 3'd0;
      stop_pend   <= 1'b0;
      halted      <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= 32'd0;
`ifdef SUBLEQ_RETIRE_CNT_EN
      retire_cnt  <= 32'd0;
`endif
    end else begin
      state       <= state_nx;
      host_rvalid <= host_rd;
      if (host_rd) host_rdata <= mem_data;

      if (run_q && state_nx == ST_RUN) begin
        phase     <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
        stop_pend <= stop_pend | host_req;
      end else begin
        phase     <= 3'd0;
        stop_pend <= 1'b0;
      end

      if (halt_hit) begin
        halted <= 1'b1;
      end else if (start_run) begin
        halted <= 1'b0;
      end

`ifdef SUBLEQ_RETIRE_CNT_EN
      if (start_run) begin
        retire_cnt <= 32'd0;
      end else if (run_q && phase == 3'd5) begin
        retire_cnt <= retire_inc;
      end
`endif
    end
  end

endmodule
